// File: rtl/reg_file_param_if.sv
// Register-file access bundle: NRD combinational read ports, one WB write port,
// plus sweep status. The master drives addresses/write data; the slave is the file.
interface reg_file_param_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                busy;
  logic                wr_drop;

  modport master (output raddr, we, waddr, wdata, input rdata, busy, wr_drop);
  modport slave  (input raddr, we, waddr, wdata, output rdata, busy, wr_drop);
endinterface

// File: rtl/reg_file_param.sv
// Parametrised ID-stage integer register file with post-reset clear sweep,
// optional hardwired x0 and optional same-cycle WB->ID bypass.
module reg_file_rd_port #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic [AW-1:0]   raddr,
  input  logic            busy,
  input  logic            wr_ok,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rdata
);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  always_comb begin
    rdata = mem_rdata;
    if (busy || ({1'b0, raddr} >= NREGS_W) || ((ZERO_REG != 0) && (raddr == '0)))
      rdata = '0;
    else if ((BYPASS != 0) && wr_ok && (waddr == raddr))
      rdata = wdata;
  end
endmodule

module reg_file_param #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_param_if.slave bus
);
  localparam int          AW      = $clog2(NREGS);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST  = AW'(NREGS-1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
  logic            busy_q, busy_d;
  logic            wr_drop_q, wr_drop_d;
  logic [XLEN-1:0] mem_q [NREGS];

  logic            mem_we;
  logic [AW-1:0]   mem_wa;
  logic [XLEN-1:0] mem_wd;
  logic            wr_ok;

  // A write that will actually land this edge; also gates the bypass path.
  assign wr_ok = bus.we && !rst && (state_q == S_RUN) &&
                 ({1'b0, bus.waddr} < NREGS_W) &&
                 !((ZERO_REG != 0) && (bus.waddr == '0));

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = bus.waddr;
    mem_wd    = bus.wdata;
    if (rst) begin
      state_d   = S_CLEAR;
      clr_ptr_d = '0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_wa    = clr_ptr_q;
          mem_wd    = '0;
          clr_ptr_d = clr_ptr_q + AW'(1);
          wr_drop_d = bus.we;
          if (clr_ptr_q == LAST) begin
            state_d = S_RUN;
            busy_d  = 1'b0;
          end
        end
        default: mem_we = wr_ok;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    clr_ptr_q <= clr_ptr_d;
    busy_q    <= busy_d;
    wr_drop_q <= wr_drop_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign bus.busy    = busy_q;
  assign bus.wr_drop = wr_drop_q;

  logic [NRD-1:0][AW-1:0]   raddr_a;
  logic [NRD-1:0][XLEN-1:0] rdata_a;
  assign raddr_a   = bus.raddr;
  assign bus.rdata = rdata_a;

  // Out-of-range array reads are masked inside the port, never observed.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [XLEN-1:0] mem_rd;
    assign mem_rd = mem_q[raddr_a[k]];
    reg_file_rd_port #(
      .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .AW(AW)
    ) u_rd (
      .raddr    (raddr_a[k]),
      .busy     (busy_q),
      .wr_ok    (wr_ok),
      .waddr    (bus.waddr),
      .wdata    (bus.wdata),
      .mem_rdata(mem_rd),
      .rdata    (rdata_a[k])
    );
  end
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: default config checked every cycle against a
// behavioural model, plus directed checks on no-bypass, wide and odd-depth configs.
module tb_reg_file_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

  reg_file_param_if #(.XLEN(32), .NREGS(32), .NRD(2)) ia ();
  reg_file_param_if #(.XLEN(32), .NREGS(32), .NRD(2)) ib ();
  reg_file_param_if #(.XLEN(64), .NREGS(16), .NRD(3)) ic ();
  reg_file_param_if #(.XLEN(32), .NREGS(24), .NRD(2)) id ();

  reg_file_param #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1))
    u_a (.clk(clk), .rst(rst_a), .bus(ia));
  reg_file_param #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(0))
    u_b (.clk(clk), .rst(rst_b), .bus(ib));
  reg_file_param #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0), .BYPASS(1))
    u_c (.clk(clk), .rst(rst_c), .bus(ic));
  reg_file_param #(.XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(1), .BYPASS(1))
    u_d (.clk(clk), .rst(rst_d), .bus(id));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Behavioural model of DUT A: a reset empties the file and blocks it for 32 edges.
  logic [31:0] m_mem [32];
  int          m_left  = 0;
  bit          m_drop  = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst_a) begin
      m_valid <= 1'b1;
      m_left  <= 32;
      m_drop  <= 1'b0;
      for (int i = 0; i < 32; i++) m_mem[i] <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_drop <= ia.we;
    end else begin
      m_drop <= 1'b0;
      if (ia.we && ia.waddr != 5'd0) m_mem[ia.waddr] <= ia.wdata;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (m_left > 0 || a == 5'd0) return 32'h0;
    if (ia.we && !rst_a && ia.waddr == a) return ia.wdata;
    return m_mem[a];
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      chk("a_busy", 64'(ia.busy), 64'(m_left > 0));
      chk("a_wr_drop", 64'(ia.wr_drop), 64'(m_drop));
      for (int k = 0; k < 2; k++)
        chk($sformatf("a_rdata%0d", k), 64'(ia.rdata[k*32 +: 32]),
            64'(exp_rd(ia.raddr[k*5 +: 5])));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_cnt;
    ia.we = 0; ia.waddr = '0; ia.wdata = '0; ia.raddr = '0;
    ib.we = 0; ib.waddr = '0; ib.wdata = '0; ib.raddr = '0;
    ic.we = 0; ic.waddr = '0; ic.wdata = '0; ic.raddr = '0;
    id.we = 0; id.waddr = '0; id.wdata = '0; id.raddr = '0;
    tick;
    rst_a = 0; rst_b = 0; rst_c = 0; rst_d = 0;
    chk("a_reset_wr_drop", 64'(ia.wr_drop), 64'h0);

    // First sweep, with a write attempted mid-sweep.
    busy_cnt = 0;
    for (int c = 0; c < 40 && ia.busy; c++) begin
      busy_cnt++;
      ia.we = (c == 3); ia.waddr = 5'd5; ia.wdata = 32'hDEADBEEF;
      ia.raddr = {5'd5, 5'd5};
      if (c == 4) chk("a_sweep_wr_drop", 64'(ia.wr_drop), 64'h1);
      tick;
    end
    ia.we = 0;
    chk("a_sweep_len", 64'(busy_cnt), 64'd32);
    for (int a = 0; a < 32; a++) begin
      ia.raddr = {5'(a), 5'(a)};
      #1;
      chk("a_cleared_p0", 64'(ia.rdata[31:0]), 64'h0);
      chk("a_cleared_p1", 64'(ia.rdata[63:32]), 64'h0);
    end
    tick;

    // Write/read and x0.
    ia.we = 1; ia.waddr = 5'd7; ia.wdata = 32'h12345678; ia.raddr = {5'd7, 5'd7};
    tick;
    ia.we = 0; #1;
    chk("a_x7_p0", 64'(ia.rdata[31:0]), 64'h12345678);
    chk("a_x7_p1", 64'(ia.rdata[63:32]), 64'h12345678);
    ia.we = 1; ia.waddr = 5'd0; ia.wdata = 32'hFFFFFFFF; ia.raddr = {5'd0, 5'd0}; #1;
    chk("a_x0_bypass", 64'(ia.rdata[31:0]), 64'h0);
    tick;
    ia.we = 0; #1;
    chk("a_x0_after", 64'(ia.rdata[63:32]), 64'h0);

    // Bypass on port 1 while port 0 reads a stored value.
    ia.we = 1; ia.waddr = 5'd3; ia.wdata = 32'hA5A5A5A5; ia.raddr = {5'd3, 5'd7}; #1;
    chk("a_bypass_p1", 64'(ia.rdata[63:32]), 64'hA5A5A5A5);
    chk("a_bypass_p0", 64'(ia.rdata[31:0]), 64'h12345678);
    tick;

    // Reset together with a write in RUN, then reset again mid-sweep.
    rst_a = 1; ia.we = 1; ia.waddr = 5'd9; ia.wdata = 32'h1;
    tick;
    rst_a = 0; ia.we = 0;
    chk("a_rst_we_drop", 64'(ia.wr_drop), 64'h0);
    repeat (10) tick;
    rst_a = 1;
    tick;
    rst_a = 0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && ia.busy; c++) begin
      busy_cnt++;
      ia.we = (c == 31); ia.waddr = 5'd9; ia.wdata = 32'h99;
      tick;
    end
    ia.we = 0;
    chk("a_resweep_len", 64'(busy_cnt), 64'd32);
    chk("a_last_step_drop", 64'(ia.wr_drop), 64'h1);
    ia.raddr = {5'd7, 5'd9}; #1;
    chk("a_x9_dropped", 64'(ia.rdata[31:0]), 64'h0);
    chk("a_x7_recleared", 64'(ia.rdata[63:32]), 64'h0);
    tick;

    // No bypass: old value in the write cycle, new value after.
    chk("b_busy", 64'(ib.busy), 64'h0);
    ib.we = 1; ib.waddr = 5'd3; ib.wdata = 32'hA5A5A5A5; ib.raddr = {5'd3, 5'd0}; #1;
    chk("b_nobyp_old0", 64'(ib.rdata[63:32]), 64'h0);
    tick;
    ib.we = 0; #1;
    chk("b_nobyp_new", 64'(ib.rdata[63:32]), 64'hA5A5A5A5);
    ib.we = 1; ib.wdata = 32'h5A5A5A5A; #1;
    chk("b_nobyp_old1", 64'(ib.rdata[63:32]), 64'hA5A5A5A5);
    tick;
    ib.we = 0; #1;
    chk("b_nobyp_new1", 64'(ib.rdata[63:32]), 64'h5A5A5A5A);

    // 64-bit, 16 entries, 3 ports, writable entry 0.
    rst_c = 1;
    tick;
    rst_c = 0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && ic.busy; c++) begin
      busy_cnt++;
      tick;
    end
    chk("c_sweep_len", 64'(busy_cnt), 64'd16);
    ic.we = 1; ic.waddr = 4'd0; ic.wdata = 64'h0123456789ABCDEF;
    ic.raddr = {4'd0, 4'd0, 4'd0}; #1;
    chk("c_bypass_x0", ic.rdata[63:0], 64'h0123456789ABCDEF);
    tick;
    ic.we = 0; #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("c_x0_p%0d", k), ic.rdata[k*64 +: 64], 64'h0123456789ABCDEF);
    ic.raddr = {4'd15, 4'd1, 4'd15}; #1;
    chk("c_x15", ic.rdata[63:0], 64'h0);

    // 24 entries: out-of-range address neither written nor read.
    chk("d_busy", 64'(id.busy), 64'h0);
    id.we = 1; id.waddr = 5'd30; id.wdata = 32'h1; id.raddr = {5'd30, 5'd14}; #1;
    chk("d_oor_bypass", 64'(id.rdata[63:32]), 64'h0);
    tick;
    id.we = 0; #1;
    chk("d_oor_read", 64'(id.rdata[63:32]), 64'h0);
    chk("d_alias14", 64'(id.rdata[31:0]), 64'h0);
    id.raddr = {5'd6, 5'd23}; #1;
    chk("d_alias6", 64'(id.rdata[63:32]), 64'h0);
    id.we = 1; id.waddr = 5'd23; id.wdata = 32'h0000CAFE;
    tick;
    id.we = 0; #1;
    chk("d_last_entry", 64'(id.rdata[31:0]), 64'h0000CAFE);
    chk("d_alias6_after", 64'(id.rdata[63:32]), 64'h0);

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
